// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_access_unit_pkg                                             |
// | Purpose  : Shared types and defaults for the load/store unit: FSM state    |
// |            encoding, request opcode struct, default widths/depth, and a    |
// |            helper that flags malformed requests.                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package mem_access_unit_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int ADDR_W_DEF    = 32;
  localparam int OFF_W_DEF     = 16;
  localparam int MEM_DEPTH_DEF = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic is_load;
    logic is_store;
  } op_t;

  // A request must be exactly one of load or store.
  function automatic logic op_invalid(input op_t op);
    return op.is_load == op.is_store;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_access_unit_if                                              |
// | Purpose  : Data-memory bus between the load/store unit (master) and        |
// |            Data_memory (slave).                                            |
// | Signals  : mem_addr     word address to memory                            |
// |            mem_data_in  store data to memory                              |
// |            MemRd/MemWr  read / write strobes                              |
// |            mem_data_out read data from memory                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              MemRd;
  logic              MemWr;

  modport master (
    output mem_addr,
    output mem_data_in,
    output MemRd,
    output MemWr,
    input  mem_data_out
  );

  modport slave (
    input  mem_addr,
    input  mem_data_in,
    input  MemRd,
    input  MemWr,
    output mem_data_out
  );

endinterface
`default_nettype wire

// File: rtl/mem_access_unit_ea_calc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ea_calc                                                         |
// | Purpose  : Effective-address generation: base + sign-extended offset       |
// |            (wraps modulo 2^ADDR_W) plus an out-of-range flag.              |
// | Ports    : base   in  ADDR_W  base register value                          |
// |            offset in  OFF_W   signed immediate                             |
// |            ea     out ADDR_W  effective address                            |
// |            oob    out 1       ea >= MEM_DEPTH                              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ea_calc #(
  parameter int ADDR_W    = 32,
  parameter int OFF_W     = 16,
  parameter int MEM_DEPTH = 256
) (
  input  wire logic [ADDR_W-1:0] base,
  input  wire logic [OFF_W-1:0]  offset,
  output logic      [ADDR_W-1:0] ea,
  output logic                   oob
);

  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(MEM_DEPTH);

  logic [ADDR_W-1:0] off_sext;

  assign off_sext = {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset};
  assign ea       = base + off_sext;
  assign oob      = (ea >= DEPTH);

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_access_unit                                                 |
// | Purpose  : Load/store initiator for the data memory. Accepts one request   |
// |            per start pulse, bounds-checks the effective address, runs the  |
// |            memory access over several cycles and signals completion with a |
// |            one-cycle done pulse (fault set when no access was made).       |
// | Ports    : clk, rst_n           clock, async active-low reset              |
// |            start/is_load/is_store/base/offset/wdata  request (IDLE only)   |
// |            busy/done/fault/load_data                 status and result     |
// |            mem                  data-memory bus (master modport)           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int OFF_W      = OFF_W_DEF,
  parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
  parameter int RD_LATENCY = 1
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              start,
  input  wire logic              is_load,
  input  wire logic              is_store,
  input  wire logic [ADDR_W-1:0] base,
  input  wire logic [OFF_W-1:0]  offset,
  input  wire logic [DATA_W-1:0] wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   fault,
  output logic      [DATA_W-1:0] load_data,
  mem_access_unit_if.master      mem
);

  localparam int               CNT_W   = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LATENCY - 1);

  state_t            state;
  state_t            state_nx;
  op_t               op_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] ea_q;
  logic              oob_q;
  logic              fault_q;
  logic [CNT_W-1:0]  rd_cnt;

  logic [ADDR_W-1:0] ea_w;
  logic              oob_w;
  logic              accept;
  logic              rd_last;
  logic              bad_req;

  ea_calc #(
    .ADDR_W    (ADDR_W),
    .OFF_W     (OFF_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_ea_calc (
    .base   (base),
    .offset (offset),
    .ea     (ea_w),
    .oob    (oob_w)
  );

  assign accept  = (state == ST_IDLE) && start;
  assign rd_last = (rd_cnt == RD_LAST);
  assign bad_req = op_invalid(op_q) || oob_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Strobes and status decode from state only, so no input can reach
  // MemRd/MemWr combinationally; the async reset of state drops them at once.
  always_comb begin
    state_nx        = state;
    busy            = (state != ST_IDLE);
    done            = (state == ST_DONE);
    fault           = (state == ST_DONE) && fault_q;
    mem.MemRd       = (state == ST_READ);
    mem.MemWr       = (state == ST_WRITE);
    mem.mem_addr    = ea_q;
    mem.mem_data_in = '0;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_CALC;
      ST_CALC: begin
        if (bad_req)              state_nx = ST_DONE;
        else if (op_q.is_load)    state_nx = ST_READ;
        else                      state_nx = ST_WRITE;
      end
      ST_READ:  if (rd_last) state_nx = ST_DONE;
      ST_WRITE: begin
        mem.mem_data_in = wdata_q;
        state_nx        = ST_DONE;
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      wdata_q   <= '0;
      ea_q      <= '0;
      oob_q     <= 1'b0;
      fault_q   <= 1'b0;
      rd_cnt    <= '0;
      load_data <= '0;
    end else begin
      // Request fields are captured only on acceptance; later input activity
      // has no effect until the unit is back in IDLE.
      if (accept) begin
        op_q    <= {is_load, is_store};
        wdata_q <= wdata;
        ea_q    <= ea_w;
        oob_q   <= oob_w;
      end
      if (state == ST_CALC) begin
        fault_q <= bad_req;
      end
      // rd_cnt marks which MemRd cycle we are in; the last one captures data.
      if (state == ST_READ) begin
        rd_cnt <= rd_last ? '0 : rd_cnt + CNT_W'(1);
        if (rd_last) begin
          load_data <= mem.mem_data_out;
        end
      end else begin
        rd_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire
